// File: rtl/nyq_polyphase_decim_pkg.sv
// Shared definitions for the polyphase Nyquist decimator: control-word layout
// and the output round-shift / saturate helpers.
package nyq_polyphase_decim_pkg;

  localparam int NYQ_MAX_W      = 128;
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BYP_BIT   = 1;
  localparam int CTRL_SHIFT_LSB = 4;
  localparam int CTRL_SHIFT_W   = 4;

  typedef struct packed {
    logic [CTRL_SHIFT_W-1:0] shift;
    logic                    byp;
    logic                    en;
  } nyq_ctrl_t;

  typedef logic signed [NYQ_MAX_W-1:0] nyq_wide_t;

  function automatic nyq_ctrl_t ctrl_decode(input logic [7:0] w);
    nyq_ctrl_t c;
    c.en    = w[CTRL_EN_BIT];
    c.byp   = w[CTRL_BYP_BIT];
    c.shift = w[CTRL_SHIFT_LSB +: CTRL_SHIFT_W];
    return c;
  endfunction

  // Round half up, then arithmetic shift right; shift of zero passes through.
  function automatic nyq_wide_t round_shift(input nyq_wide_t v,
                                            input logic [CTRL_SHIFT_W-1:0] sh);
    nyq_wide_t half;
    if (sh == '0) return v;
    half = nyq_wide_t'(1) <<< (sh - 4'd1);
    return (v + half) >>> sh;
  endfunction

  function automatic nyq_wide_t saturate(input nyq_wide_t v, input int ow);
    nyq_wide_t hi;
    nyq_wide_t lo;
    hi = (nyq_wide_t'(1) <<< (ow - 1)) - nyq_wide_t'(1);
    lo = -(nyq_wide_t'(1) <<< (ow - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nyq_polyphase_decim_mac_stage.sv
// One polyphase MAC stage: loads or accumulates x*c and exposes the
// post-accumulate value f_o combinationally for the block-end delay chain.
module nyq_mac_stage #(
  parameter int ACC_WIDTH  = 48,
  parameter int IN_WIDTH   = 24,
  parameter int COEF_WIDTH = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic                         load_i,
  input  logic signed [IN_WIDTH-1:0]   x_i,
  input  logic signed [COEF_WIDTH-1:0] c_i,
  output logic signed [ACC_WIDTH-1:0]  f_o
);

  localparam int PW = IN_WIDTH + COEF_WIDTH;

  logic signed [PW-1:0]        prod_full;
  logic signed [ACC_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;

  assign prod_full = PW'(x_i) * PW'(c_i);
  assign prod      = ACC_WIDTH'(prod_full);

  always_comb begin
    acc_base = acc_q;
    if (load_i) acc_base = '0;
    f_o = acc_base + prod;
  end

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = f_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

endmodule

// File: rtl/nyq_polyphase_decim.sv
// K-stage polyphase Nyquist decimator (transposed MAC chain, decimation OSR)
// with parameter-memory programming, bypass, flush and round/saturate output.
module nyq_polyphase_decim
  import nyq_polyphase_decim_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int MEM_WIDTH  = 24,
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 24,
  parameter int COEF_WIDTH = 24,
  parameter int ACC_WIDTH  = 48,
  parameter int NUM_STAGES = 4,
  parameter int OSR        = 256
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RBI,
  input  logic                        WrEn_SI,
  input  logic [ADDR_WIDTH-1:0]       Addr_DI,
  input  logic signed [MEM_WIDTH-1:0] PAR_In_DI,
  input  logic                        NYQ_InValid_SI,
  input  logic signed [IN_WIDTH-1:0]  NYQ_In_DI,
  output logic signed [OUT_WIDTH-1:0] NYQ_Out_DO,
  output logic                        NYQ_Valid_DO,
  output logic [$clog2(OSR)-1:0]      NYQ_Phase_DO
);

  localparam int K     = NUM_STAGES;
  localparam int PW    = $clog2(OSR);
  localparam int NCOEF = NUM_STAGES * OSR;
  localparam int IW    = $clog2(NCOEF);
  localparam int DN    = (K > 1) ? K - 1 : 1;
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR  = ADDR_WIDTH'(1) << (ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] COEF_LIMIT = ADDR_WIDTH'(NCOEF);
  localparam logic [PW-1:0]         PHASE_LAST = PW'(OSR - 1);

  if (NCOEF > 2 ** (ADDR_WIDTH - 1)) begin : g_err_len
    $error("NUM_STAGES*OSR exceeds the coefficient address region");
  end
  if (OSR < 2 || (OSR & (OSR - 1)) != 0) begin : g_err_osr
    $error("OSR must be a power of two and at least 2");
  end
  if (ACC_WIDTH < IN_WIDTH + COEF_WIDTH || ACC_WIDTH > NYQ_MAX_W - 1) begin : g_err_acc
    $error("ACC_WIDTH out of range");
  end
  if (COEF_WIDTH > MEM_WIDTH || MEM_WIDTH < 8) begin : g_err_mem
    $error("MEM_WIDTH must hold the coefficient and the control byte");
  end

  logic signed [COEF_WIDTH-1:0] coef_q [NCOEF];
  nyq_ctrl_t                    ctrl_q, ctrl_d, ctrl_wr;
  logic [PW-1:0]                phase_q, phase_d;
  logic signed [OUT_WIDTH-1:0]  out_q, out_d;
  logic                         vld_q, vld_d;
  logic signed [ACC_WIDTH-1:0]  d_q [DN];
  logic signed [ACC_WIDTH-1:0]  f [K];
  logic signed [ACC_WIDTH-1:0]  y;
  logic wr_ctrl, wr_coef, flush, accept, blk_end, mac_en, mac_load;

  assign ctrl_wr  = ctrl_decode(PAR_In_DI[7:0]);
  assign wr_ctrl  = WrEn_SI && (Addr_DI == CTRL_ADDR);
  assign wr_coef  = WrEn_SI && (Addr_DI < COEF_LIMIT);
  // Disabling or switching mode restarts the block from a clean state.
  assign flush    = wr_ctrl && (!ctrl_wr.en || (ctrl_wr.byp != ctrl_q.byp));
  assign accept   = NYQ_InValid_SI && ctrl_q.en && !flush;
  assign blk_end  = accept && (phase_q == PHASE_LAST);
  assign mac_en   = accept && !ctrl_q.byp;
  assign mac_load = (phase_q == '0);

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < NCOEF; i++) coef_q[i] <= '0;
    end else if (wr_coef) begin
      coef_q[Addr_DI[IW-1:0]] <= $signed(PAR_In_DI[COEF_WIDTH-1:0]);
    end
  end

  for (genvar k = 0; k < K; k++) begin : g_stage
    localparam logic [IW-1:0] BASE = IW'((K - 1 - k) * OSR);
    logic [IW-1:0] rd_idx;

    assign rd_idx = BASE + IW'(phase_q);

    nyq_mac_stage #(
      .ACC_WIDTH (ACC_WIDTH),
      .IN_WIDTH  (IN_WIDTH),
      .COEF_WIDTH(COEF_WIDTH)
    ) u_mac (
      .clk_i (Clk_CI),
      .rst_ni(Rst_RBI),
      .clr_i (flush),
      .en_i  (mac_en),
      .load_i(mac_load),
      .x_i   (NYQ_In_DI),
      .c_i   (coef_q[rd_idx]),
      .f_o   (f[k])
    );
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < DN; i++) d_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DN; i++) d_q[i] <= '0;
    end else if (blk_end && !ctrl_q.byp) begin
      d_q[0] <= f[0];
      for (int i = 1; i < K - 1; i++) d_q[i] <= f[i] + d_q[i-1];
    end
  end

  always_comb begin
    y = f[K-1];
    if (K > 1) y = f[K-1] + d_q[DN-1];
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl) ctrl_d = ctrl_wr;
    phase_d = phase_q;
    if (flush)       phase_d = '0;
    else if (accept) phase_d = phase_q + PW'(1);
  end

  always_comb begin
    out_d = out_q;
    vld_d = 1'b0;
    if (blk_end) begin
      vld_d = 1'b1;
      if (ctrl_q.byp)
        out_d = OUT_WIDTH'(saturate(nyq_wide_t'(NYQ_In_DI), OUT_WIDTH));
      else
        out_d = OUT_WIDTH'(saturate(round_shift(nyq_wide_t'(y), ctrl_q.shift), OUT_WIDTH));
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      ctrl_q  <= '0;
      phase_q <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      phase_q <= phase_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  assign NYQ_Out_DO   = out_q;
  assign NYQ_Valid_DO = vld_q;
  assign NYQ_Phase_DO = phase_q;

endmodule
